// File: rtl/bnn_top.sv
// Binarized CNN inference engine: streams in a 28x28 binarized image, 4x4
// conv kernels and FC weights, then runs one 4x4/stride-4 XNOR-popcount conv
// layer followed by an XNOR-popcount fully connected layer, emitting one
// score per class.
module bnn_top #(
    parameter int IMG_PIX = 784,
    parameter int NK      = 8,
    parameter int NCLS    = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_cnn,
    input  logic               image_tvalid,
    input  logic signed [31:0] image_tdata,
    output logic               image_tready,
    input  logic               weight_tvalid,
    input  logic               weight_tdata,
    output logic               weight_tready,
    input  logic               weightfc_tvalid,
    input  logic               weightfc_tdata,
    output logic               weightfc_tready,
    output logic               cnn_done,
    output logic               result_tvalid,
    output logic signed [31:0] result_tdata,
    output logic [3:0]         conv_cnt
);

    localparam int CW_BITS = NK * 16;
    localparam int NFEAT   = NK * 49;
    localparam int FC_BITS = NCLS * NFEAT;
    localparam int IMG_AW  = $clog2(IMG_PIX);
    localparam int CW_AW   = $clog2(CW_BITS);
    localparam int FC_AW   = $clog2(FC_BITS);
    localparam int FEAT_AW = $clog2(NFEAT);
    localparam int K_W     = $clog2(NK);
    localparam int CLS_W   = $clog2(NCLS + 1);

    localparam logic [IMG_AW:0]    IMG_FULL = (IMG_AW + 1)'(IMG_PIX);
    localparam logic [CW_AW:0]     CW_FULL  = (CW_AW + 1)'(CW_BITS);
    localparam logic [FC_AW:0]     FC_FULL  = (FC_AW + 1)'(FC_BITS);
    localparam logic [FEAT_AW-1:0] LAST_F   = FEAT_AW'(NFEAT - 1);
    localparam logic [CLS_W-1:0]   LAST_CLS = CLS_W'(NCLS);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_FC, S_DONE} state_t;

    state_t r_state, w_next;

    logic [IMG_PIX-1:0] r_img;
    logic [CW_BITS-1:0] r_cw;
    logic [FC_BITS-1:0] r_fcw;
    logic [NFEAT-1:0]   r_feat;

    logic [IMG_AW:0] r_img_cnt;
    logic [CW_AW:0]  r_cw_cnt;
    logic [FC_AW:0]  r_fc_cnt;
    logic            r_rdy;

    logic [K_W-1:0]     r_k;
    logic [2:0]         r_or, r_oc;
    logic [FEAT_AW-1:0] r_fi, r_f;
    logic [CLS_W-1:0]   r_cls;
    logic [FEAT_AW:0]   r_acc;

    logic               w_all_full;
    logic [4:0]         w_pop;
    logic [FC_AW-1:0]   w_fcidx;
    logic               w_fbit;
    logic [FEAT_AW:0]   w_pc;
    logic signed [31:0] w_score;
    logic               w_img_hs, w_cw_hs, w_fc_hs;

    assign w_all_full = (r_img_cnt == IMG_FULL) && (r_cw_cnt == CW_FULL) && (r_fc_cnt == FC_FULL);
    assign w_img_hs   = image_tvalid && image_tready;
    assign w_cw_hs    = weight_tvalid && weight_tready;
    assign w_fc_hs    = weightfc_tvalid && weightfc_tready;

    // XNOR-popcount of the current 4x4 image window against kernel r_k
    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                w_pop = w_pop + 5'(r_img[IMG_AW'((32'(r_or) * 4 + i) * 28 + 32'(r_oc) * 4 + j)]
                                   ~^ r_cw[CW_AW'(32'(r_k) * 16 + i * 4 + j)]);
            end
        end
    end

    // FC term for the current class/feature; the trailing pass (r_cls == NCLS)
    // only pads timing so DONE lands one class-period after the last score
    always_comb begin
        w_fcidx = (r_cls == LAST_CLS) ? '0 : FC_AW'(32'(r_cls) * NFEAT + 32'(r_f));
        w_fbit  = r_feat[r_f] ~^ r_fcw[w_fcidx];
        w_pc    = r_acc + (FEAT_AW + 1)'(w_fbit);
        w_score = $signed(32'({w_pc, 1'b0})) - 32'(NFEAT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rstn) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_cnn && w_all_full) w_next = S_CONV;
            S_CONV: if (r_fi == LAST_F) w_next = S_FC;
            S_FC:   if (r_f == LAST_F && r_cls == LAST_CLS) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        image_tready    = !rstn && r_rdy && (r_state == S_IDLE) && (r_img_cnt != IMG_FULL);
        weight_tready   = !rstn && r_rdy && (r_state == S_IDLE) && (r_cw_cnt != CW_FULL);
        weightfc_tready = !rstn && r_rdy && (r_state == S_IDLE) && (r_fc_cnt != FC_FULL);
        conv_cnt        = (r_state == S_CONV) ? 4'(r_k) : 4'd0;
    end

    // Bit buffers (contents need no reset; validity is tracked by the counts)
    always_ff @(posedge clk) begin
        if (w_img_hs) r_img[r_img_cnt[IMG_AW-1:0]] <= (image_tdata > 0);
        if (w_cw_hs)  r_cw[r_cw_cnt[CW_AW-1:0]]    <= weight_tdata;
        if (w_fc_hs)  r_fcw[r_fc_cnt[FC_AW-1:0]]   <= weightfc_tdata;
        if (r_state == S_CONV) r_feat[r_fi] <= (w_pop >= 5'd8);
    end

    // Buffer counts, conv/FC sequencing and registered results
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_img_cnt     <= '0;
            r_cw_cnt      <= '0;
            r_fc_cnt      <= '0;
            r_rdy         <= 1'b0;
            r_k           <= '0;
            r_or          <= '0;
            r_oc          <= '0;
            r_fi          <= '0;
            r_f           <= '0;
            r_cls         <= '0;
            r_acc         <= '0;
            result_tvalid <= 1'b0;
            result_tdata  <= '0;
            cnn_done      <= 1'b0;
        end else begin
            r_rdy         <= 1'b1;
            result_tvalid <= 1'b0;
            cnn_done      <= 1'b0;
            if (w_img_hs) r_img_cnt <= r_img_cnt + 1'b1;
            if (w_cw_hs)  r_cw_cnt  <= r_cw_cnt + 1'b1;
            if (w_fc_hs)  r_fc_cnt  <= r_fc_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_k   <= '0;
                    r_or  <= '0;
                    r_oc  <= '0;
                    r_fi  <= '0;
                    r_f   <= '0;
                    r_cls <= '0;
                    r_acc <= '0;
                end
                S_CONV: begin
                    r_fi <= r_fi + 1'b1;
                    if (r_oc == 3'd6) begin
                        r_oc <= '0;
                        if (r_or == 3'd6) begin
                            r_or <= '0;
                            r_k  <= r_k + 1'b1;
                        end else begin
                            r_or <= r_or + 1'b1;
                        end
                    end else begin
                        r_oc <= r_oc + 1'b1;
                    end
                end
                S_FC: begin
                    if (r_f == LAST_F) begin
                        r_f   <= '0;
                        r_acc <= '0;
                        r_cls <= r_cls + 1'b1;
                        if (r_cls != LAST_CLS) begin
                            result_tdata  <= w_score;
                            result_tvalid <= 1'b1;
                        end
                    end else begin
                        r_f   <= r_f + 1'b1;
                        r_acc <= w_pc;
                    end
                end
                S_DONE: begin
                    cnn_done  <= 1'b1;
                    r_img_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_top.sv
// Self-checking bench for bnn_top: a transaction-level model tracks buffer
// fills, computes class scores from the loaded bits, and predicts every
// output each cycle relative to the start edge E0.
module tb_bnn_top;

    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic               start_cnn = 1'b0;
    logic               image_tvalid = 1'b0;
    logic signed [31:0] image_tdata = '0;
    logic               image_tready;
    logic               weight_tvalid = 1'b0;
    logic               weight_tdata = 1'b0;
    logic               weight_tready;
    logic               weightfc_tvalid = 1'b0;
    logic               weightfc_tdata = 1'b0;
    logic               weightfc_tready;
    logic               cnn_done;
    logic               result_tvalid;
    logic signed [31:0] result_tdata;
    logic [3:0]         conv_cnt;

    bnn_top #(.IMG_PIX(784), .NK(8), .NCLS(10)) dut (
        .clk(clk), .rstn(rstn), .start_cnn(start_cnn),
        .image_tvalid(image_tvalid), .image_tdata(image_tdata), .image_tready(image_tready),
        .weight_tvalid(weight_tvalid), .weight_tdata(weight_tdata), .weight_tready(weight_tready),
        .weightfc_tvalid(weightfc_tvalid), .weightfc_tdata(weightfc_tdata), .weightfc_tready(weightfc_tready),
        .cnn_done(cnn_done), .result_tvalid(result_tvalid), .result_tdata(result_tdata),
        .conv_cnt(conv_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // stimulus sources
    int src_pix[800];
    bit src_cw[128];
    bit src_fc[3920];

    // ---------------- behavioural model ----------------
    bit m_img[784];
    bit m_cw[128];
    bit m_fc[3920];
    bit m_feat[392];
    int m_score[10];
    int cnt_img = 0, cnt_cw = 0, cnt_fc = 0;
    bit m_rdy = 0, m_run = 0;
    int m_t = 0;
    int runs_done = 0;
    bit e_valid = 0, e_done = 0;
    int e_data = 0;

    function automatic void compute_scores();
        for (int k = 0; k < 8; k++)
            for (int orr = 0; orr < 7; orr++)
                for (int oc = 0; oc < 7; oc++) begin
                    int pop = 0;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            if (m_img[(orr*4+i)*28 + oc*4+j] == m_cw[k*16+i*4+j]) pop++;
                    m_feat[k*49+orr*7+oc] = (pop >= 8);
                end
        for (int n = 0; n < 10; n++) begin
            int match = 0;
            for (int f = 0; f < 392; f++)
                if (m_feat[f] == m_fc[n*392+f]) match++;
            m_score[n] = 2*match - 392;
        end
    endfunction

    always @(posedge clk) begin
        if (rstn) begin
            cnt_img = 0; cnt_cw = 0; cnt_fc = 0;
            m_rdy = 0; m_run = 0; e_valid = 0; e_done = 0; e_data = 0;
        end else begin
            e_valid = 0;
            e_done  = 0;
            if (!m_run) begin
                if (start_cnn && cnt_img == 784 && cnt_cw == 128 && cnt_fc == 3920) begin
                    m_run = 1;
                    m_t   = 0;
                    compute_scores();
                end else if (m_rdy) begin
                    if (image_tvalid && cnt_img < 784) begin m_img[cnt_img] = (image_tdata > 0); cnt_img++; end
                    if (weight_tvalid && cnt_cw < 128) begin m_cw[cnt_cw] = weight_tdata; cnt_cw++; end
                    if (weightfc_tvalid && cnt_fc < 3920) begin m_fc[cnt_fc] = weightfc_tdata; cnt_fc++; end
                end
                m_rdy = 1;
            end else begin
                m_t++;
                if (m_t % 392 == 0 && m_t >= 784 && m_t <= 392*11) begin
                    e_valid = 1;
                    e_data  = m_score[m_t/392 - 2];
                end
                if (m_t == 4705) begin
                    e_done = 1; m_run = 0; cnt_img = 0; runs_done++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_res = 0;
    always @(posedge clk) begin
        longint e_rdy, a_rdy, e_ctl, a_ctl;
        int e_cc;
        #2;
        e_rdy = {61'd0, m_rdy && !m_run && cnt_img < 784,
                        m_rdy && !m_run && cnt_cw < 128,
                        m_rdy && !m_run && cnt_fc < 3920};
        a_rdy = {61'd0, image_tready, weight_tready, weightfc_tready};
        chk("tready{img,cw,fc}", a_rdy, e_rdy);
        e_cc  = (m_run && m_t < 392) ? m_t / 49 : 0;
        e_ctl = longint'(e_cc) * 4 + longint'(e_valid) * 2 + longint'(e_done);
        a_ctl = longint'(conv_cnt) * 4 + longint'(result_tvalid) * 2 + longint'(cnn_done);
        chk("ctrl{conv_cnt,valid,done}", a_ctl, e_ctl);
        chk("result_tdata", longint'(result_tdata), longint'(e_data));
        if (result_tvalid) n_res++;
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(input int n);
        @(negedge clk);
        rstn = 1'b1;
        repeat (n) @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic load(input int s, input int nb, input int bound, output int acc);
        int  idx = 0;
        int  cyc = 0;
        logic hs;
        while (idx < nb && cyc < bound) begin
            @(negedge clk);
            case (s)
                0: begin image_tvalid = 1'b1; image_tdata = src_pix[idx]; hs = image_tready; end
                1: begin weight_tvalid = 1'b1; weight_tdata = src_cw[idx]; hs = weight_tready; end
                default: begin weightfc_tvalid = 1'b1; weightfc_tdata = src_fc[idx]; hs = weightfc_tready; end
            endcase
            @(posedge clk);
            if (hs) idx++;
            cyc++;
        end
        @(negedge clk);
        image_tvalid = 1'b0; weight_tvalid = 1'b0; weightfc_tvalid = 1'b0;
        acc = idx;
    endtask

    task automatic load_all();
        int acc;
        load(0, 784, 900, acc);   chk("img_transfers", acc, 784);
        load(1, 128, 200, acc);   chk("cw_transfers", acc, 128);
        load(2, 3920, 4000, acc); chk("fc_transfers", acc, 3920);
    endtask

    task automatic wait_runs(input int target, input int bound);
        int c = 0;
        while (runs_done < target && c < bound) begin @(negedge clk); c++; end
        chk("run_completed", longint'(runs_done >= target), 1);
    endtask

    task automatic wait_t(input int target, input int bound);
        int c = 0;
        while (!(m_run && m_t >= target) && c < bound) begin @(negedge clk); c++; end
        chk("reached_t", longint'(m_run && m_t >= target), 1);
    endtask

    initial begin
        int prev, acc;
        do_reset(3);

        // all-ones case, start asserted before FC weights finish loading
        for (int i = 0; i < 800; i++) src_pix[i] = 5;
        for (int i = 0; i < 128; i++) src_cw[i] = 1'b1;
        for (int i = 0; i < 3920; i++) src_fc[i] = 1'b1;
        start_cnn = 1'b1;
        prev = runs_done; n_res = 0;
        load_all();
        wait_runs(prev + 1, 6000);
        chk("model_score0_allones", m_score[0], 392);
        chk("model_score9_allones", m_score[9], 392);
        chk("results_run1", n_res, 10);

        // overlong image burst; weights retained, start still high -> auto restart
        for (int i = 784; i < 800; i++) src_pix[i] = -3;
        n_res = 0;
        load(0, 800, 800, acc);
        chk("img_burst_accepted", acc, 784);
        wait_runs(prev + 2, 6000);
        chk("results_run2", n_res, 10);

        // per-class FC weight patterns; start dropped mid-run
        start_cnn = 1'b0;
        do_reset(2);
        for (int n = 0; n < 10; n++)
            for (int f = 0; f < 392; f++)
                src_fc[n*392+f] = (n == 0) ? 1'b1 : (n == 1) ? 1'b0 : ((f % 2) == 0);
        prev = runs_done; n_res = 0;
        load_all();
        @(negedge clk); start_cnn = 1'b1;
        wait_t(100, 200);
        start_cnn = 1'b0;
        wait_runs(prev + 1, 6000);
        chk("model_score0_pattern", m_score[0], 392);
        chk("model_score1_pattern", m_score[1], -392);
        chk("model_score2_pattern", m_score[2], 0);
        chk("results_pattern", n_res, 10);

        // negative pixels, reset during FC class 4, then full reload
        do_reset(2);
        for (int i = 0; i < 800; i++) src_pix[i] = -3;
        for (int i = 0; i < 3920; i++) src_fc[i] = 1'b1;
        start_cnn = 1'b1;
        prev = runs_done; n_res = 0;
        load_all();
        wait_t(2100, 3000);
        chk("results_before_abort", n_res, 4);
        do_reset(2);
        repeat (20) @(negedge clk);
        chk("results_after_abort", n_res, 4);
        load_all();
        wait_runs(prev + 1, 6000);
        chk("model_score5_negpix", m_score[5], -392);
        chk("results_after_reload", n_res, 14);

        // random content exercises window/kernel/feature indexing
        start_cnn = 1'b0;
        do_reset(2);
        for (int i = 0; i < 800; i++) src_pix[i] = int'($urandom_range(0, 20)) - 10;
        for (int i = 0; i < 128; i++) src_cw[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3920; i++) src_fc[i] = 1'($urandom_range(0, 1));
        prev = runs_done; n_res = 0;
        load_all();
        @(negedge clk); start_cnn = 1'b1;
        wait_runs(prev + 1, 6000);
        chk("results_random", n_res, 10);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
